// File: rtl/fb_read_arbiter.sv
// Frame-buffer read-port arbiter: display (port 0) vs pixel processing (port 1) with a
// starvation guard and latency-matched data return. Define FBARB_STATS_EN for grant statistics.
module fb_read_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [DATA_W-1:0] fb_data,
  input  logic              stat_clr,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [7:0]        stat_maxwait
);

  typedef struct packed {
    logic vld;
    logic port;
  } tag_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic              en_ok_q;
  logic              en_eff;
  logic              gnt0_c, gnt1_c;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  tag_t [RD_LAT-1:0] tag_q, tag_d;
  tag_t              tag_out;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // en_ok_q keeps arbitration off until the first edge after reset release.
  assign en_eff = en & en_ok_q;

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (en_eff) begin
      if (req1 && starve_cnt_q == STARVE_LIM) gnt1_c = 1'b1;
      else if (req0)                          gnt0_c = 1'b1;
      else if (req1)                          gnt1_c = 1'b1;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (en_eff) begin
      if (gnt1_c || !req1)              starve_cnt_d = '0;
      else if (starve_cnt_q < STARVE_LIM) starve_cnt_d = starve_cnt_q + 8'd1;
    end
  end

  always_comb begin
    fb_addr_d = fb_addr_q;
    if (gnt0_c)      fb_addr_d = addr0;
    else if (gnt1_c) fb_addr_d = addr1;
  end

  always_comb begin
    tag_d          = tag_q;
    tag_d[0].vld   = gnt0_c | gnt1_c;
    tag_d[0].port  = gnt1_c;
    for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];
    tag_out   = tag_q[RD_LAT-1];
    rvalid0_d = tag_out.vld & ~tag_out.port;
    rvalid1_d = tag_out.vld & tag_out.port;
    rd_data_d = tag_out.vld ? fb_data : rd_data_q;
  end

  // NOTE: state uses non-blocking assignments; the tag pipeline is reset so in-flight reads vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_ok_q      <= 1'b0;
      starve_cnt_q <= '0;
      fb_addr_q    <= '0;
      tag_q        <= '0;
      rvalid0_q    <= 1'b0;
      rvalid1_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      en_ok_q      <= 1'b1;
      starve_cnt_q <= starve_cnt_d;
      fb_addr_q    <= fb_addr_d;
      tag_q        <= tag_d;
      rvalid0_q    <= rvalid0_d;
      rvalid1_q    <= rvalid1_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign gnt0    = gnt0_c;
  assign gnt1    = gnt1_c;
  assign fb_addr = fb_addr_d;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rd_data = rd_data_q;

`ifdef FBARB_STATS_EN
  logic [15:0] stat_gnt0_q, stat_gnt0_d;
  logic [15:0] stat_gnt1_q, stat_gnt1_d;
  logic [7:0]  stat_maxwait_q, stat_maxwait_d;

  always_comb begin
    stat_gnt0_d    = stat_gnt0_q;
    stat_gnt1_d    = stat_gnt1_q;
    stat_maxwait_d = stat_maxwait_q;
    if (stat_clr) begin
      stat_gnt0_d    = '0;
      stat_gnt1_d    = '0;
      stat_maxwait_d = '0;
    end else begin
      if (gnt0_c && stat_gnt0_q != 16'hFFFF) stat_gnt0_d = stat_gnt0_q + 16'd1;
      if (gnt1_c && stat_gnt1_q != 16'hFFFF) stat_gnt1_d = stat_gnt1_q + 16'd1;
      if (gnt1_c && starve_cnt_q > stat_maxwait_q) stat_maxwait_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0_q    <= '0;
      stat_gnt1_q    <= '0;
      stat_maxwait_q <= '0;
    end else begin
      stat_gnt0_q    <= stat_gnt0_d;
      stat_gnt1_q    <= stat_gnt1_d;
      stat_maxwait_q <= stat_maxwait_d;
    end
  end

  assign stat_gnt0    = stat_gnt0_q;
  assign stat_gnt1    = stat_gnt1_q;
  assign stat_maxwait = stat_maxwait_q;
`else
  logic stat_clr_unused;
  assign stat_clr_unused = stat_clr;
  assign stat_gnt0       = '0;
  assign stat_gnt1       = '0;
  assign stat_maxwait    = '0;
`endif

endmodule

// File: tb/tb_fb_read_arbiter.sv
// Self-checking bench for fb_read_arbiter: a cycle-level model built from the arbitration
// rules plus directed scenarios with hand-computed expectations.
module tb_fb_read_arbiter;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;
`ifdef FBARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              req0 = 1'b0, req1 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data = '0;
  logic              stat_clr = 1'b0;
  logic [15:0]       stat_gnt0, stat_gnt1;
  logic [7:0]        stat_maxwait;

  int n_tests = 0;
  int n_fail  = 0;

  fb_read_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rd_data(rd_data), .fb_addr(fb_addr), .fb_data(fb_data),
    .stat_clr(stat_clr), .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_maxwait(stat_maxwait)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_f(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Frame-buffer model: the address seen in cycle c returns data in cycle c+RD_LAT.
  logic [ADDR_W-1:0] addr_hist [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) addr_hist[i] = '0;
  always @(negedge clk) begin
    for (int i = RD_LAT - 1; i > 0; i--) addr_hist[i] = addr_hist[i-1];
    addr_hist[0] = fb_addr;
  end
  always @(posedge clk) fb_data <= ram_f(addr_hist[RD_LAT-1]);

  // Arbitration may only start once a clock edge has been seen after reset release.
  logic armed;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;

  // Cycle model: expected deliveries are kept per future cycle number.
  int                m_cyc = 0;
  int                m_starve = 0;
  logic [ADDR_W-1:0] m_fb_addr = '0;
  logic [DATA_W-1:0] m_rd_data = '0;
  int                m_sg0 = 0, m_sg1 = 0, m_smax = 0;
  int                sched_port [int];
  logic [DATA_W-1:0] sched_data [int];
  logic              e_en, e_g0, e_g1, e_rv0, e_rv1;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_gnt0", 32'(gnt0), 0);
      check("rst_gnt1", 32'(gnt1), 0);
      check("rst_rvalid0", 32'(rvalid0), 0);
      check("rst_rvalid1", 32'(rvalid1), 0);
      check("rst_rd_data", 32'(rd_data), 0);
      check("rst_fb_addr", 32'(fb_addr), 0);
      check("rst_stat_gnt0", 32'(stat_gnt0), 0);
      check("rst_stat_gnt1", 32'(stat_gnt1), 0);
      check("rst_stat_maxwait", 32'(stat_maxwait), 0);
      m_cyc = 0; m_starve = 0; m_fb_addr = '0; m_rd_data = '0;
      m_sg0 = 0; m_sg1 = 0; m_smax = 0;
      sched_port.delete();
      sched_data.delete();
    end else begin
      e_en   = en && armed;
      e_g1   = e_en && req1 && (m_starve == STARVE_MAX || !req0);
      e_g0   = e_en && req0 && !e_g1;
      e_addr = e_g0 ? addr0 : (e_g1 ? addr1 : m_fb_addr);
      e_rv0  = 1'b0;
      e_rv1  = 1'b0;
      e_data = m_rd_data;
      if (sched_port.exists(m_cyc)) begin
        e_rv0  = (sched_port[m_cyc] == 0);
        e_rv1  = (sched_port[m_cyc] == 1);
        e_data = sched_data[m_cyc];
      end
      check("gnt0", 32'(gnt0), 32'(e_g0));
      check("gnt1", 32'(gnt1), 32'(e_g1));
      check("fb_addr", 32'(fb_addr), 32'(e_addr));
      check("rvalid0", 32'(rvalid0), 32'(e_rv0));
      check("rvalid1", 32'(rvalid1), 32'(e_rv1));
      check("rd_data", 32'(rd_data), 32'(e_data));
      check("stat_gnt0", 32'(stat_gnt0), 32'(m_sg0));
      check("stat_gnt1", 32'(stat_gnt1), 32'(m_sg1));
      check("stat_maxwait", 32'(stat_maxwait), 32'(m_smax));

      m_fb_addr = e_addr;
      m_rd_data = e_data;
      if (e_g0 || e_g1) begin
        sched_port[m_cyc + RD_LAT + 1] = e_g1 ? 1 : 0;
        sched_data[m_cyc + RD_LAT + 1] = ram_f(e_addr);
      end
`ifdef FBARB_STATS_EN
      if (stat_clr) begin
        m_sg0 = 0; m_sg1 = 0; m_smax = 0;
      end else begin
        if (e_g0 && m_sg0 < 65535) m_sg0++;
        if (e_g1 && m_sg1 < 65535) m_sg1++;
        if (e_g1 && m_starve > m_smax) m_smax = m_starve;
      end
`endif
      if (e_en) begin
        if (req1 && !e_g1) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : m_starve;
        else               m_starve = 0;
      end
      m_cyc++;
    end
  end

  task automatic set_in(input logic e, input logic r0, input logic [ADDR_W-1:0] a0,
                        input logic r1, input logic [ADDR_W-1:0] a1);
    en = e; req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int n_g1, first_g1, n_grant, rv_seen;

  initial begin
    // Reset with en and req0 already high: nothing may be granted.
    set_in(1, 1, 15'h0005, 0, 15'h0000);
    step(); step(); step();
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("a_unarmed_gnt0", 32'(gnt0), 0);
    step();
    @(negedge clk);
    check("a_gnt0", 32'(gnt0), 1);
    check("a_fb_addr", 32'(fb_addr), 32'h0005);
    step();
    set_in(1, 0, 15'h0777, 0, 15'h0000);
    @(negedge clk);
    check("a_fb_addr_hold", 32'(fb_addr), 32'h0005);
    check("a_rvalid0_early", 32'(rvalid0), 0);
    step();
    @(negedge clk);
    check("a_rvalid0", 32'(rvalid0), 1);
    check("a_rd_data", 32'(rd_data), 32'hA5);
    check("a_rvalid1", 32'(rvalid1), 0);
    step();

    // Both ports requesting continuously: 8x port 0 then 1x port 1.
    n_g1 = 0; first_g1 = -1;
    for (int i = 0; i < 18; i++) begin
      set_in(1, 1, 15'(32'h0100 + i), 1, 15'(32'h7F00 + i));
      @(negedge clk);
      if (gnt1) begin
        n_g1++;
        if (first_g1 < 0) first_g1 = i;
      end
      step();
    end
    check("b_gnt1_count", 32'(n_g1), 2);
    check("b_first_gnt1", 32'(first_g1), 8);
    set_in(1, 0, 15'h0000, 0, 15'h0000);
    step(); step(); step();

    // Build a wait of 3, freeze it with en low, then resume.
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 15'(32'h0200 + i), 1, 15'h0300);
      step();
    end
    n_grant = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 15'h0210, 1, 15'h0310);
      @(negedge clk);
      if (gnt0 || gnt1) n_grant++;
      step();
    end
    check("c_no_grant_en_low", 32'(n_grant), 0);
    first_g1 = -1;
    for (int i = 0; i < 6; i++) begin
      set_in(1, 1, 15'(32'h0400 + i), 1, 15'h0500);
      @(negedge clk);
      if (gnt1 && first_g1 < 0) first_g1 = i;
      step();
    end
    check("c_first_gnt1_after_resume", 32'(first_g1), 5);

    // en drops the cycle after a grant; that read must still return.
    set_in(1, 0, 15'h0000, 1, 15'h1234);
    @(negedge clk);
    check("c_drop_gnt1", 32'(gnt1), 1);
    step();
    set_in(0, 0, 15'h0000, 1, 15'h1235);
    @(negedge clk);
    check("c_drop_no_gnt", 32'(gnt1), 0);
    step();
    @(negedge clk);
    check("c_drop_rvalid1", 32'(rvalid1), 1);
    check("c_drop_rd_data", 32'(rd_data), 32'h86);
    step();
    set_in(1, 0, 15'h0000, 0, 15'h0000);
    step();

    // Reset one cycle after a grant drops the read entirely.
    set_in(1, 0, 15'h0000, 1, 15'h0042);
    @(negedge clk);
    check("d_gnt1", 32'(gnt1), 1);
    step();
    set_in(0, 0, 15'h0000, 0, 15'h0000);
    rst_n = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) rv_seen++;
      check("d_rst_rd_data", 32'(rd_data), 0);
      step();
    end
    #1 rst_n = 1'b1;
    set_in(1, 0, 15'h0000, 0, 15'h0000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) rv_seen++;
      step();
    end
    check("d_no_rvalid", 32'(rv_seen), 0);

    // Statistics: 20 port 0 grants, 3 port 1 grants, longest wait 5.
    set_in(1, 0, 15'h0000, 0, 15'h0000);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    set_in(1, 0, 15'h0000, 1, 15'h0010);
    step();
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 15'(32'h0020 + i), 1, 15'h0011);
      step();
    end
    set_in(1, 0, 15'h0000, 1, 15'h0012);
    step();
    for (int i = 0; i < 15; i++) begin
      set_in(1, 1, 15'(32'h0030 + i), 0, 15'h0000);
      step();
    end
    set_in(1, 0, 15'h0000, 1, 15'h0013);
    step();
    set_in(1, 0, 15'h0000, 0, 15'h0000);
    @(negedge clk);
    check("e_stat_gnt0", 32'(stat_gnt0), STATS ? 20 : 0);
    check("e_stat_gnt1", 32'(stat_gnt1), STATS ? 3 : 0);
    check("e_stat_maxwait", 32'(stat_maxwait), STATS ? 5 : 0);
    step();
    // Clear wins over a grant in the same cycle.
    set_in(1, 1, 15'h0040, 0, 15'h0000);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    set_in(1, 0, 15'h0000, 0, 15'h0000);
    @(negedge clk);
    check("e_clr_gnt0", 32'(stat_gnt0), 0);
    check("e_clr_gnt1", 32'(stat_gnt1), 0);
    check("e_clr_maxwait", 32'(stat_maxwait), 0);
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_read_arbiter.md
# fb_read_arbiter

Shares the single read port of the camera frame buffer (15-bit address, 8-bit pixel) between two requesters: port 0, the display scanout path (real-time, normally preferred), and port 1, the pixel-processing path (laser-spot detection). It makes a grant decision every cycle and drives the buffer read address. A tag pipeline returns read data to the correct requester after the RAM latency. A starvation counter guarantees port 1 forward progress.

## Interface

Parameters:
- ADDR_W, 15, frame buffer address width
- DATA_W, 8, pixel width
- RD_LAT, 1, frame buffer read latency in cycles from address to data (legal 1..4)
- STARVE_MAX, 8, consecutive denied cycles after which port 1 is forced to win (legal 1..255)

Ports:
- clk  in  1  system clock; also drives the frame buffer read port
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbitration enable (tied to camera config-finished); low = no new grants
- req0  in  1  display read request
- addr0  in  ADDR_W  display read address
- gnt0  out  1  display request accepted this cycle
- rvalid0  out  1  rd_data valid for display
- req1  in  1  processing read request
- addr1  in  ADDR_W  processing read address
- gnt1  out  1  processing request accepted this cycle
- rvalid1  out  1  rd_data valid for processing
- rd_data  out  DATA_W  registered read data, shared by both ports
- fb_addr  out  ADDR_W  frame buffer read address
- fb_data  in  DATA_W  frame buffer read data
- stat_clr  in  1  clear statistics (see Configuration)
- stat_gnt0  out  16  port 0 grant count
- stat_gnt1  out  16  port 1 grant count
- stat_maxwait  out  8  longest port 1 wait observed

## Operation

- Grant rule (combinational, evaluated each cycle):
  - en low: gnt0=gnt1=0.
  - Else, if req1 and starve_cnt==STARVE_MAX: gnt1=1.
  - Else, if req0: gnt0=1.
  - Else, if req1: gnt1=1.
- At most one grant per cycle. gnt is the acceptance; the requester may change addr/req the next cycle.
- fb_addr = addr of the granted port; it holds its last value when there is no grant.
- starve_cnt (registered, 8 bits):
  - Increments when req1 && !gnt1 && en.
  - Clears on gnt1 or !req1.
  - Holds while en is low.
  - Never exceeds STARVE_MAX.
- Tag pipeline: RD_LAT+1 stages of {valid, port}, loaded from the grant each cycle.
  - At stage RD_LAT, fb_data is registered into rd_data, and rvalid0 or rvalid1 pulses for one cycle.
  - rd_data holds its value between valid pulses.
- en falling mid-operation: in-flight reads still complete and deliver rvalid; only new grants stop.
- Port 0 is expected to buffer at least STARVE_MAX+1 pixels to absorb a forced port 1 cycle.
- rst_n asserted: all registers clear immediately, including in-flight tags. Reads in flight are dropped with no rvalid.

## Timing

- Reset values: gnt0=gnt1=0 (en forced inactive internally until the first clk edge after release), rvalid0=rvalid1=0, rd_data=0, fb_addr=0, starve_cnt=0, stats=0.
- Grant latency: 0 cycles (gnt is valid in the same cycle as req).
- Read latency: rvalid and rd_data appear exactly RD_LAT+1 cycles after the grant cycle.
- Throughput: one read per cycle, aggregate across both ports.
- Simultaneous req0 and req1 with starve_cnt<STARVE_MAX: port 0 wins and starve_cnt increments.
- With both ports requesting continuously, the grant pattern is STARVE_MAX×gnt0, then 1×gnt1, repeating.

## Configuration

- FBARB_STATS_EN defined:
  - stat_gnt0 and stat_gnt1 count grants, saturating at 0xFFFF.
  - stat_maxwait tracks the maximum starve_cnt value reached before a gnt1.
  - All three clear synchronously on stat_clr; stat_clr has priority over counting in the same cycle.
- FBARB_STATS_EN undefined:
  - stat_* outputs are constant 0 and stat_clr is ignored.
  - No counter logic is synthesized.

## Test plan

- Reset, then en=1, req0=1 only, addr0=0x0005, fb_data=0xA5 at the RAM: gnt0 in the same cycle, fb_addr=0x0005; rvalid0=1 and rd_data=0xA5 two cycles later (RD_LAT=1); rvalid1 stays 0.
- req0 and req1 held high, STARVE_MAX=8: grants repeat 8×gnt0 then 1×gnt1; the rvalid sequence matches, offset by RD_LAT+1.
- en=0 with both requests high: no grants and starve_cnt frozen. en=1 restores normal arbitration. Dropping en one cycle after a grant still yields that grant's rvalid.
- Assert rst_n low one cycle after a grant: no rvalid is ever produced, and all outputs read 0 during reset.
- With FBARB_STATS_EN, 20 port 0 grants and 3 port 1 grants (one after a 5-cycle wait): stat_gnt0=20, stat_gnt1=3, stat_maxwait=5. Pulsing stat_clr clears all three to 0. Without the macro, all three read 0.
